multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Parametrised successor of the CPU's RegWrite/MemRead/MemWrite control FSM.
- Merges the sequential and combinational control paths into one Moore-style multicycle controller for the datapath (register file, ALU, data memory, muxes).
- Adds:
  - beq and addi instruction classes.
  - Configurable data-memory wait latency.
  - Explicit start/busy/done handshake.
  - Illegal-opcode and overrun reporting.

Parameters:
- MEM_LAT, 1: number of cycles the MEM state holds MemRead/MemWrite. Legal range 1..15.
- EXT_OPS, 1: when 1, beq (opcode 4) and addi (opcode 8) are legal. When 0, both are treated as illegal.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- newinstr  in  1  start request; sampled only in IDLE.
- opcode  in  6  instrword[31:26]; captured into op_q on acceptance.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- illegal  out  1  high in DONE when op_q is unsupported.
- overrun  out  1  one-cycle pulse when newinstr=1 is sampled while busy.
- RegWrite  out  1  high only in WB (one cycle; the register file writes on its rising edge).
- MemRead  out  1  high in MEM for lw.
- MemWrite  out  1  high in MEM for sw.
- MemToReg  out  1  1 for lw, else 0.
- RegDst  out  1  1 for R-type, else 0.
- ALUSrc  out  1  1 for lw/sw/addi, else 0.
- ALUOp  out  2  R-type=2, beq=1, lw/sw/addi=0.
- Branch  out  1  high in EXEC for beq.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, op_q=0, wait counter=0.
  - All outputs 0 immediately.
  - Takes effect mid-instruction with no completion, no done and no write pulse.
  - Release is synchronous to clk.
- Outputs are decoded only from the state register and op_q. There are no combinational paths from the inputs.
- Outside busy, MemToReg/RegDst/ALUSrc/ALUOp/Branch are 0.
- States: IDLE(0), DECODE(1), EXEC(2), MEM(3), WB(4), DONE(5). Encodings 6 and 7 go to IDLE on the next edge.
- IDLE:
  - newinstr=1 → capture op_q=opcode, go to DECODE.
  - Otherwise stay.
- DECODE:
  - Legal op_q → EXEC.
  - Illegal op_q → DONE, with illegal=1 in DONE.
- EXEC next state by op_q:
  - R-type(0) / addi(8) → WB.
  - lw(35) / sw(43) → MEM, with counter loaded to MEM_LAT-1.
  - beq(4) → DONE.
- MEM:
  - counter≠0 → decrement and stay.
  - counter=0 → lw goes to WB; sw goes to DONE.
  - MEM lasts exactly MEM_LAT cycles.
- WB → DONE.
- DONE → IDLE. done=1 for exactly one cycle.
- Cycle latency from the accepting edge to the done cycle:
  - R/addi: 4 cycles.
  - beq: 3 cycles.
  - lw: 4+MEM_LAT cycles.
  - sw: 3+MEM_LAT cycles.
  - illegal: 2 cycles.
- Back-to-back: newinstr=1 in DONE is ignored without overrun. It is accepted in the following IDLE cycle if still high.
- newinstr while busy:
  - Ignored, with overrun pulsed for the cycle after the sample.
  - op_q is unchanged and the current instruction completes normally.
- opcode may change freely after acceptance without effect.
- RegWrite and MemWrite are never high in the same cycle. MemRead and MemWrite are never simultaneous.

Test Plan:
- Reset, then newinstr=1 opcode=0 at edge E0 → busy from E0; DECODE/EXEC/WB after E0/E1/E2; RegWrite=1, RegDst=1, ALUOp=2 in the cycle after E2; done=1 after E3; IDLE after E4.
- MEM_LAT=3, lw (35) → MemRead=1 for exactly 3 cycles (after E2..E4); WB after E5 with MemToReg=1, ALUSrc=1; done after E6.
- sw (43), MEM_LAT=1 → MemWrite=1 for one cycle; RegWrite never 1; done 4 cycles after acceptance.
- beq (4), EXT_OPS=1 → Branch=1 and ALUOp=1 in EXEC; done 3 cycles after acceptance. Same with EXT_OPS=0 → illegal=1 and done 2 cycles after acceptance, no control strobes.
- Opcode 63 → illegal=1 with done; newinstr pulsed during EXEC of an add → overrun=1 for one cycle, add still completes.
- Assert rst=0 asynchronously mid-MEM of lw → MemRead and busy drop immediately; after release, stays IDLE until next newinstr.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Moore-style multicycle control FSM for the single-bus datapath: sequences
// R-type/lw/sw/beq/addi through DECODE/EXEC/MEM/WB with a start/busy/done handshake.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_LAT = 1,
  parameter bit          EXT_OPS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newinstr,
  input  logic [5:0] opcode,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       overrun,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic [2:0] dbg_state
);

  // Handshake: newinstr is a request that is taken only while busy=0 (IDLE);
  // a request seen while busy is dropped and flagged on overrun; done marks
  // the single completion cycle of every accepted request.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_op_q;
  logic [3:0] r_wait_cnt;
  logic       r_overrun;

  logic w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_legal, w_in_flight;

  assign w_is_r    = (r_op_q == OP_RTYPE);
  assign w_is_lw   = (r_op_q == OP_LW);
  assign w_is_sw   = (r_op_q == OP_SW);
  assign w_is_beq  = EXT_OPS && (r_op_q == OP_BEQ);
  assign w_is_addi = EXT_OPS && (r_op_q == OP_ADDI);
  assign w_legal   = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_addi;

  // DONE is busy but a request there is a legitimate back-to-back, not an overrun.
  assign w_in_flight = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                       (r_state == S_MEM)    || (r_state == S_WB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op_q     <= '0;
      r_wait_cnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_overrun <= newinstr && w_in_flight;
      if ((r_state == S_IDLE) && newinstr) begin
        r_op_q <= opcode;
      end
      if (r_state == S_EXEC) begin
        r_wait_cnt <= CNT_LOAD;
      end else if ((r_state == S_MEM) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (newinstr) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        busy         = 1'b1;
        w_next_state = w_legal ? S_EXEC : S_DONE;
      end
      S_EXEC: begin
        busy   = 1'b1;
        Branch = w_is_beq;
        if (w_is_lw || w_is_sw)  w_next_state = S_MEM;
        else if (w_is_beq)       w_next_state = S_DONE;
        else                     w_next_state = S_WB;
      end
      S_MEM: begin
        busy     = 1'b1;
        MemRead  = w_is_lw;
        MemWrite = w_is_sw;
        if (r_wait_cnt == 4'd0) w_next_state = w_is_lw ? S_WB : S_DONE;
      end
      S_WB: begin
        busy         = 1'b1;
        RegWrite     = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        illegal      = !w_legal;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Static datapath selects follow op_q for the whole instruction, zero when idle.
  assign MemToReg  = busy && w_is_lw;
  assign RegDst    = busy && w_is_r;
  assign ALUSrc    = busy && (w_is_lw || w_is_sw || w_is_addi);
  assign ALUOp     = !busy    ? 2'd0 :
                     w_is_r   ? 2'd2 :
                     w_is_beq ? 2'd1 : 2'd0;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: two instances (MEM_LAT=3/EXT_OPS=1 and
// MEM_LAT=1/EXT_OPS=0) driven from shared inputs, table vectors plus corner sequences.
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic       newinstr;
  logic [5:0] opcode;

  logic       a_busy, a_done, a_illegal, a_overrun, a_rw, a_mr, a_mw, a_m2r, a_rdst, a_asrc, a_br;
  logic [1:0] a_aluop;
  logic [2:0] a_state;
  logic       b_busy, b_done, b_illegal, b_overrun, b_rw, b_mr, b_mw, b_m2r, b_rdst, b_asrc, b_br;
  logic [1:0] b_aluop;
  logic [2:0] b_state;

  multicycle_ctrl_fsm #(.MEM_LAT(3), .EXT_OPS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .newinstr(newinstr), .opcode(opcode),
    .busy(a_busy), .done(a_done), .illegal(a_illegal), .overrun(a_overrun),
    .RegWrite(a_rw), .MemRead(a_mr), .MemWrite(a_mw), .MemToReg(a_m2r),
    .RegDst(a_rdst), .ALUSrc(a_asrc), .ALUOp(a_aluop), .Branch(a_br),
    .dbg_state(a_state)
  );

  multicycle_ctrl_fsm #(.MEM_LAT(1), .EXT_OPS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .newinstr(newinstr), .opcode(opcode),
    .busy(b_busy), .done(b_done), .illegal(b_illegal), .overrun(b_overrun),
    .RegWrite(b_rw), .MemRead(b_mr), .MemWrite(b_mw), .MemToReg(b_m2r),
    .RegDst(b_rdst), .ALUSrc(b_asrc), .ALUOp(b_aluop), .Branch(b_br),
    .dbg_state(b_state)
  );

  // {busy,done,illegal,overrun,RegWrite,MemRead,MemWrite,MemToReg,RegDst,ALUSrc,ALUOp[1:0],Branch}
  logic [12:0] vec_a, vec_b;
  assign vec_a = {a_busy, a_done, a_illegal, a_overrun, a_rw, a_mr, a_mw, a_m2r, a_rdst, a_asrc, a_aluop, a_br};
  assign vec_b = {b_busy, b_done, b_illegal, b_overrun, b_rw, b_mr, b_mw, b_m2r, b_rdst, b_asrc, b_aluop, b_br};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0] op;
    int         a_k;
    logic       a_ill;
    int         a_rw, a_mr, a_mw, a_br;
    int         b_k;
    logic       b_ill;
    int         b_rw, b_mr, b_mw, b_br;
  } instr_t;

  instr_t tbl[7];

  // Pulse newinstr for one edge, then watch both instances for 10 cycles.
  // k = number of edges after the accepting edge at which done is visible.
  task automatic run_instr(input int idx);
    int   a_k, b_k, a_dn, b_dn;
    logic a_ill, b_ill;
    int   a_rwc, a_mrc, a_mwc, a_brc, b_rwc, b_mrc, b_mwc, b_brc, clash;
    a_k = -1; b_k = -1; a_dn = 0; b_dn = 0; a_ill = 1'b0; b_ill = 1'b0;
    a_rwc = 0; a_mrc = 0; a_mwc = 0; a_brc = 0;
    b_rwc = 0; b_mrc = 0; b_mwc = 0; b_brc = 0; clash = 0;
    opcode   = tbl[idx].op;
    newinstr = 1'b1;
    step();
    newinstr = 1'b0;
    opcode   = 6'($urandom_range(0, 63));
    for (int k = 0; k < 10; k++) begin
      if (a_done) begin
        if (a_k < 0) begin a_k = k; a_ill = a_illegal; end
        a_dn++;
      end
      if (b_done) begin
        if (b_k < 0) begin b_k = k; b_ill = b_illegal; end
        b_dn++;
      end
      a_rwc += int'(a_rw); a_mrc += int'(a_mr); a_mwc += int'(a_mw); a_brc += int'(a_br);
      b_rwc += int'(b_rw); b_mrc += int'(b_mr); b_mwc += int'(b_mw); b_brc += int'(b_br);
      if ((a_rw && a_mw) || (a_mr && a_mw) || (b_rw && b_mw) || (b_mr && b_mw)) clash++;
      step();
    end
    chk($sformatf("op%0d A done_k", tbl[idx].op), 32'(a_k), 32'(tbl[idx].a_k));
    chk($sformatf("op%0d A done_cnt", tbl[idx].op), 32'(a_dn), 32'd1);
    chk($sformatf("op%0d A illegal", tbl[idx].op), 32'(a_ill), 32'(tbl[idx].a_ill));
    chk($sformatf("op%0d A RegWrite_cycles", tbl[idx].op), 32'(a_rwc), 32'(tbl[idx].a_rw));
    chk($sformatf("op%0d A MemRead_cycles", tbl[idx].op), 32'(a_mrc), 32'(tbl[idx].a_mr));
    chk($sformatf("op%0d A MemWrite_cycles", tbl[idx].op), 32'(a_mwc), 32'(tbl[idx].a_mw));
    chk($sformatf("op%0d A Branch_cycles", tbl[idx].op), 32'(a_brc), 32'(tbl[idx].a_br));
    chk($sformatf("op%0d B done_k", tbl[idx].op), 32'(b_k), 32'(tbl[idx].b_k));
    chk($sformatf("op%0d B done_cnt", tbl[idx].op), 32'(b_dn), 32'd1);
    chk($sformatf("op%0d B illegal", tbl[idx].op), 32'(b_ill), 32'(tbl[idx].b_ill));
    chk($sformatf("op%0d B RegWrite_cycles", tbl[idx].op), 32'(b_rwc), 32'(tbl[idx].b_rw));
    chk($sformatf("op%0d B MemRead_cycles", tbl[idx].op), 32'(b_mrc), 32'(tbl[idx].b_mr));
    chk($sformatf("op%0d B MemWrite_cycles", tbl[idx].op), 32'(b_mwc), 32'(tbl[idx].b_mw));
    chk($sformatf("op%0d B Branch_cycles", tbl[idx].op), 32'(b_brc), 32'(tbl[idx].b_br));
    chk($sformatf("op%0d strobe_clash", tbl[idx].op), 32'(clash), 32'd0);
    chk($sformatf("op%0d idle_after", tbl[idx].op), 32'({a_busy, b_busy}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [12:0] R_DEC  = 13'b1_0_0_0_0_0_0_0_1_0_10_0;
  localparam logic [12:0] R_WB   = 13'b1_0_0_0_1_0_0_0_1_0_10_0;
  localparam logic [12:0] R_WBOV = 13'b1_0_0_1_1_0_0_0_1_0_10_0;
  localparam logic [12:0] R_DONE = 13'b1_1_0_0_0_0_0_0_1_0_10_0;
  localparam logic [12:0] L_BASE = 13'b1_0_0_0_0_0_0_1_0_1_00_0;
  localparam logic [12:0] L_MEM  = 13'b1_0_0_0_0_1_0_1_0_1_00_0;
  localparam logic [12:0] L_WB   = 13'b1_0_0_0_1_0_0_1_0_1_00_0;
  localparam logic [12:0] L_DONE = 13'b1_1_0_0_0_0_0_1_0_1_00_0;
  localparam logic [12:0] S_DEC  = 13'b1_0_0_0_0_0_0_0_0_1_00_0;
  localparam logic [12:0] Q_DEC  = 13'b1_0_0_0_0_0_0_0_0_0_01_0;
  localparam logic [12:0] Q_EXEC = 13'b1_0_0_0_0_0_0_0_0_0_01_1;
  localparam logic [12:0] Q_DONE = 13'b1_1_0_0_0_0_0_0_0_0_01_0;
  localparam logic [12:0] I_DEC  = 13'b1_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] I_DONE = 13'b1_1_1_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] IDLE_V = 13'b0;

  logic [12:0] lw_exp[8];

  initial begin
    tbl[0] = '{6'd0,  3, 1'b0, 1, 0, 0, 0,  3, 1'b0, 1, 0, 0, 0};
    tbl[1] = '{6'd35, 6, 1'b0, 1, 3, 0, 0,  4, 1'b0, 1, 1, 0, 0};
    tbl[2] = '{6'd43, 5, 1'b0, 0, 0, 3, 0,  3, 1'b0, 0, 0, 1, 0};
    tbl[3] = '{6'd4,  2, 1'b0, 0, 0, 0, 1,  1, 1'b1, 0, 0, 0, 0};
    tbl[4] = '{6'd8,  3, 1'b0, 1, 0, 0, 0,  1, 1'b1, 0, 0, 0, 0};
    tbl[5] = '{6'd63, 1, 1'b1, 0, 0, 0, 0,  1, 1'b1, 0, 0, 0, 0};
    tbl[6] = '{6'd2,  1, 1'b1, 0, 0, 0, 0,  1, 1'b1, 0, 0, 0, 0};
    lw_exp = '{L_BASE, L_BASE, L_MEM, L_MEM, L_MEM, L_WB, L_DONE, IDLE_V};

    rst = 1'b0; newinstr = 1'b0; opcode = 6'd0;
    idle_cycles(2);
    chk("reset A outputs", 32'(vec_a), 32'(IDLE_V));
    chk("reset A state", 32'(a_state), 32'd0);
    chk("reset B outputs", 32'(vec_b), 32'(IDLE_V));
    #3 rst = 1'b1;
    step();
    chk("post-reset A outputs", 32'(vec_a), 32'(IDLE_V));

    // R-type cycle by cycle.
    opcode = 6'd0; newinstr = 1'b1;
    step(); newinstr = 1'b0; opcode = 6'd43;
    chk("rtype E0 outs", 32'(vec_a), 32'(R_DEC));
    chk("rtype E0 state", 32'(a_state), 32'd1);
    step();
    chk("rtype E1 outs", 32'(vec_a), 32'(R_DEC));
    chk("rtype E1 state", 32'(a_state), 32'd2);
    step();
    chk("rtype E2 outs", 32'(vec_a), 32'(R_WB));
    chk("rtype E2 state", 32'(a_state), 32'd4);
    step();
    chk("rtype E3 outs", 32'(vec_a), 32'(R_DONE));
    step();
    chk("rtype E4 outs", 32'(vec_a), 32'(IDLE_V));
    chk("rtype E4 state", 32'(a_state), 32'd0);
    idle_cycles(2);

    // lw with MEM_LAT=3 on A.
    opcode = 6'd35; newinstr = 1'b1;
    step(); newinstr = 1'b0; opcode = 6'd0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lw E%0d outs", k), 32'(vec_a), 32'(lw_exp[k]));
      step();
    end
    idle_cycles(2);

    // beq: legal on A, illegal on B.
    opcode = 6'd4; newinstr = 1'b1;
    step(); newinstr = 1'b0;
    chk("beq E0 A", 32'(vec_a), 32'(Q_DEC));
    chk("beq E0 B", 32'(vec_b), 32'(I_DEC));
    step();
    chk("beq E1 A", 32'(vec_a), 32'(Q_EXEC));
    chk("beq E1 B", 32'(vec_b), 32'(I_DONE));
    step();
    chk("beq E2 A", 32'(vec_a), 32'(Q_DONE));
    chk("beq E2 B", 32'(vec_b), 32'(IDLE_V));
    step();
    chk("beq E3 A", 32'(vec_a), 32'(IDLE_V));
    idle_cycles(2);

    // Overrun: request raised during EXEC of an add, opcode changed meanwhile.
    opcode = 6'd0; newinstr = 1'b1;
    step(); newinstr = 1'b0;
    step();
    chk("ovr EXEC state", 32'(a_state), 32'd2);
    newinstr = 1'b1; opcode = 6'd35;
    step(); newinstr = 1'b0;
    chk("ovr WB outs", 32'(vec_a), 32'(R_WBOV));
    step();
    chk("ovr DONE outs", 32'(vec_a), 32'(R_DONE));
    step();
    chk("ovr idle outs", 32'(vec_a), 32'(IDLE_V));
    idle_cycles(2);

    // Back-to-back: request in DONE ignored, then taken in the following IDLE.
    opcode = 6'd0; newinstr = 1'b1;
    step(); newinstr = 1'b0;
    idle_cycles(2);
    step();
    chk("b2b DONE", 32'(vec_a), 32'(R_DONE));
    opcode = 6'd43; newinstr = 1'b1;
    step();
    chk("b2b IDLE no overrun", 32'(vec_a), 32'(IDLE_V));
    step(); newinstr = 1'b0;
    chk("b2b accepted sw", 32'(vec_a), 32'(S_DEC));
    idle_cycles(8);
    chk("b2b idle after sw", 32'({a_busy, b_busy}), 32'd0);

    for (int i = 0; i < 7; i++) run_instr(i);

    // Asynchronous reset in the middle of lw MEM.
    opcode = 6'd35; newinstr = 1'b1;
    step(); newinstr = 1'b0;
    idle_cycles(3);
    chk("rstmid MEM outs", 32'(vec_a), 32'(L_MEM));
    #2 rst = 1'b0;
    #1;
    chk("rstmid immediate A", 32'(vec_a), 32'(IDLE_V));
    chk("rstmid immediate B", 32'(vec_b), 32'(IDLE_V));
    @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rstmid idle %0d", k), 32'({a_state, vec_a}), 32'd0);
    end
    run_instr(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
